// File: rtl/mash_pkg.sv
// Shared types and constants for the MASH modulator input sequencer.
// Holds the FSM encoding and the fixed flush/drain lengths.
package mash_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam int DATA_W_DEF = 4;
  localparam int FLUSH_CYC  = 2;
  localparam int DRAIN_CYC  = 4;
  localparam int CNT_W      = 3;

endpackage

// File: rtl/mash_phase_cnt.sv
// Sample-phase counter: loads to the last phase, wraps at last.
// boundary flags the final clock of each sample period.
module mash_phase_cnt #(
  parameter int W = 8
) (
  input  logic         clck,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] last,
  output logic         boundary
);

  logic [W-1:0] phase;

  assign boundary = (phase == last);

  always_ff @(posedge clck) begin
    if (rst) begin
      phase <= '0;
    end else if (load) begin
      phase <= last;
    end else if (en) begin
      phase <= boundary ? '0 : phase + 1'b1;
    end
  end

endmodule

// File: rtl/mash_sequencer.sv
// Feeds oversampled samples into a MASH truncator chain and
// sequences its flush, run and drain phases.
module mash_sequencer
  import mash_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int OSR_W  = 8
) (
  input  logic                     clck,
  input  logic                     rst,
  input  logic                     en,
  input  logic [OSR_W-1:0]         osr,
  input  logic signed [DATA_W-1:0] s_data,
  input  logic                     s_valid,
  output logic                     s_ready,
  output logic signed [DATA_W-1:0] x_out,
  output logic                     stage_en,
  output logic                     stage_rst,
  output logic                     underrun,
  input  logic                     clr_underrun,
  output logic                     busy,
  output logic [1:0]               state_o
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [OSR_W-1:0] osr_eff;
  logic [OSR_W-1:0] last;
  logic             boundary;
  logic             accept;

  assign last   = osr_eff - OSR_W'(1);
  assign accept = (state == RUN) && boundary && en;

  mash_phase_cnt #(.W(OSR_W)) u_phase (
    .clck     (clck),
    .rst      (rst),
    .load     (state == FLUSH),
    .en       (state == RUN),
    .last     (last),
    .boundary (boundary)
  );

  assign s_ready   = accept;
  assign stage_en  = (state != IDLE);
  assign stage_rst = (state == IDLE) || (state == FLUSH);
  assign busy      = (state != IDLE);
  assign state_o   = state;

  always_ff @(posedge clck) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      x_out    <= '0;
      underrun <= 1'b0;
      osr_eff  <= OSR_W'(1);
    end else begin
      // a starved accept wins over a same-cycle clear
      if (clr_underrun) underrun <= 1'b0;
      if (accept && !s_valid) underrun <= 1'b1;
      unique case (state)
        IDLE: begin
          x_out <= '0;
          if (en) begin
            state   <= FLUSH;
            cnt     <= '0;
            osr_eff <= (osr == '0) ? OSR_W'(1) : osr;
          end
        end
        FLUSH: begin
          x_out <= '0;
          if (cnt == CNT_W'(FLUSH_CYC - 1)) begin
            state <= RUN;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RUN: begin
          if (boundary) begin
            if (en) begin
              x_out <= s_valid ? s_data : '0;
            end else begin
              state <= DRAIN;
              cnt   <= '0;
              x_out <= '0;
            end
          end
        end
        DRAIN: begin
          x_out <= '0;
          if (cnt == CNT_W'(DRAIN_CYC - 1)) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mash_sequencer.sv
// Bench for mash_sequencer: vector table, directed corner
// sequences and random traffic against a timeline model.
module tb_mash_sequencer;

  logic              clck;
  logic              rst;
  logic              en;
  logic [7:0]        osr;
  logic signed [3:0] s_data;
  logic              s_valid;
  logic              s_ready;
  logic signed [3:0] x_out;
  logic              stage_en;
  logic              stage_rst;
  logic              underrun;
  logic              clr_underrun;
  logic              busy;
  logic [1:0]        state_o;

  int total = 0;
  int bad   = 0;

  // model: mode, cycle of mode entry, cycle count, ratio, x, flag
  int m_mode  = 0;
  int m_enter = 0;
  int m_cyc   = 0;
  int m_oe    = 1;
  int m_x     = 0;
  int m_und   = 0;

  mash_sequencer #(.DATA_W(4), .OSR_W(8)) dut (
    .clck         (clck),
    .rst          (rst),
    .en           (en),
    .osr          (osr),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .x_out        (x_out),
    .stage_en     (stage_en),
    .stage_rst    (stage_rst),
    .underrun     (underrun),
    .clr_underrun (clr_underrun),
    .busy         (busy),
    .state_o      (state_o)
  );

  initial begin
    clck = 1'b0;
    forever #5 clck = ~clck;
  end

  typedef struct {
    logic       rst;
    logic       en;
    logic [7:0] osr;
    logic       v;
    logic [3:0] d;
    logic       clr;
    int         st;
    int         rdy;
    int         x;
    int         und;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", name, m_cyc, act, exp);
    end
  endtask

  function automatic int m_bnd();
    return (m_mode == 2 && ((m_cyc - m_enter) % m_oe) == 0) ? 1 : 0;
  endfunction

  task automatic apply(input logic r, input logic e, input logic [7:0] o,
                       input logic v, input logic [3:0] d, input logic c);
    rst = r; en = e; osr = o; s_valid = v; s_data = d; clr_underrun = c;
    #2;
  endtask

  task automatic check_model();
    int rdy;
    rdy = (m_bnd() == 1 && en) ? 1 : 0;
    chk("state", int'(state_o), m_mode);
    chk("s_ready", int'(s_ready), rdy);
    chk("x_out", int'(x_out), m_x);
    chk("underrun", int'(underrun), m_und);
    chk("busy", int'(busy), (m_mode != 0) ? 1 : 0);
    chk("stage_en", int'(stage_en), (m_mode != 0) ? 1 : 0);
    chk("stage_rst", int'(stage_rst), (m_mode <= 1) ? 1 : 0);
  endtask

  task automatic advance();
    int nmode, nx, nund, acc;
    nmode = m_mode;
    nx    = m_x;
    acc   = (m_bnd() == 1 && en) ? 1 : 0;
    nund  = (acc == 1 && !s_valid) ? 1 : (clr_underrun ? 0 : m_und);
    case (m_mode)
      0: begin
        nx = 0;
        if (en) begin
          nmode = 1;
          m_oe  = (osr == 0) ? 1 : int'(osr);
        end
      end
      1: begin
        nx = 0;
        if (m_cyc - m_enter == 1) nmode = 2;
      end
      2: begin
        if (m_bnd() == 1) begin
          if (en) nx = s_valid ? int'(s_data) : 0;
          else begin nmode = 3; nx = 0; end
        end
      end
      default: begin
        nx = 0;
        if (m_cyc - m_enter == 3) nmode = 0;
      end
    endcase
    if (rst) begin
      nmode = 0; nx = 0; nund = 0; m_oe = 1;
    end
    if (nmode != m_mode) m_enter = m_cyc + 1;
    m_mode = nmode;
    m_x    = nx;
    m_und  = nund;
    m_cyc++;
    @(posedge clck);
    #1;
  endtask

  task automatic step(input logic r, input logic e, input logic [7:0] o,
                      input logic v, input logic [3:0] d, input logic c);
    apply(r, e, o, v, d, c);
    check_model();
    advance();
  endtask

  task automatic do_reset();
    apply(1, 0, 0, 0, 0, 0);
    advance();
  endtask

  initial begin
    int n;
    rst = 1; en = 0; osr = 0; s_valid = 0; s_data = 0; clr_underrun = 0;
    #1;
    do_reset();
    chk("rst_state", int'(state_o), 0);
    chk("rst_x", int'(x_out), 0);
    chk("rst_stage_rst", int'(stage_rst), 1);
    chk("rst_stage_en", int'(stage_en), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_und", int'(underrun), 0);

    // osr=3 start-up: two flush cycles, accept on first RUN cycle
    tbl[0] = '{0, 1, 8'd3, 1, 4'd5, 0, 0, 0, 0, 0};
    tbl[1] = '{0, 1, 8'd3, 1, 4'd5, 0, 1, 0, 0, 0};
    tbl[2] = '{0, 1, 8'd3, 1, 4'd5, 0, 1, 0, 0, 0};
    tbl[3] = '{0, 1, 8'd3, 1, 4'd5, 0, 2, 1, 0, 0};
    tbl[4] = '{0, 1, 8'd3, 1, 4'd5, 0, 2, 0, 5, 0};
    tbl[5] = '{0, 1, 8'd3, 1, 4'd5, 0, 2, 0, 5, 0};
    tbl[6] = '{0, 1, 8'd3, 1, 4'd6, 0, 2, 1, 5, 0};
    tbl[7] = '{0, 1, 8'd3, 1, 4'd6, 0, 2, 0, 6, 0};
    for (int i = 0; i < 8; i++) begin
      apply(tbl[i].rst, tbl[i].en, tbl[i].osr, tbl[i].v, tbl[i].d, tbl[i].clr);
      chk($sformatf("tbl%0d_state", i), int'(state_o), tbl[i].st);
      chk($sformatf("tbl%0d_ready", i), int'(s_ready), tbl[i].rdy);
      chk($sformatf("tbl%0d_x", i), int'(x_out), tbl[i].x);
      chk($sformatf("tbl%0d_und", i), int'(underrun), tbl[i].und);
      check_model();
      advance();
    end

    // starvation, clear, then starve while clearing (osr=4)
    do_reset();
    for (int i = 0; i < 3; i++) step(0, 1, 4, 1, 3, 0);
    step(0, 1, 4, 0, 3, 0);
    chk("starve_x", int'(x_out), 0);
    chk("starve_und", int'(underrun), 1);
    step(0, 1, 4, 1, 3, 1);
    chk("clr_und", int'(underrun), 0);
    for (int i = 0; i < 6; i++) step(0, 1, 4, 1, 2, 0);
    step(0, 1, 4, 0, 2, 1);
    chk("set_clr_und", int'(underrun), 1);

    // osr=0 acts as 1: accept every RUN cycle
    do_reset();
    for (int i = 0; i < 3; i++) step(0, 1, 0, 1, 1, 0);
    n = 0;
    for (int i = 0; i < 5; i++) begin
      apply(0, 1, 0, 1, 4'(i + 2), 0);
      n += int'(s_ready);
      check_model();
      advance();
      chk("osr0_x", int'(x_out), i + 2);
    end
    chk("osr0_ready_cnt", n, 5);

    // en drops mid-sample at osr=5
    do_reset();
    for (int i = 0; i < 4; i++) step(0, 1, 5, 1, 7, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 5, 1, 1, 0);
      chk("hold_x", int'(x_out), 7);
    end
    apply(0, 0, 5, 1, 1, 0);
    chk("drop_no_accept", int'(s_ready), 0);
    check_model();
    advance();
    for (int i = 0; i < 4; i++) begin
      chk("drain_state", int'(state_o), 3);
      step(0, 1, 5, 1, 1, 0);
    end
    chk("drain_idle", int'(state_o), 0);
    chk("drain_stage_rst", int'(stage_rst), 1);

    // osr change during RUN is ignored
    do_reset();
    for (int i = 0; i < 3; i++) step(0, 1, 3, 1, 2, 0);
    n = 0;
    for (int i = 0; i < 9; i++) begin
      apply(0, 1, 7, 1, 2, 0);
      n += int'(s_ready);
      check_model();
      advance();
    end
    chk("osr_latch_cnt", n, 3);

    // reset in mid-RUN with en held high
    step(1, 1, 3, 1, 2, 0);
    chk("mid_rst_state", int'(state_o), 0);
    chk("mid_rst_x", int'(x_out), 0);
    chk("mid_rst_stage_en", int'(stage_en), 0);
    chk("mid_rst_busy", int'(busy), 0);
    step(0, 1, 3, 1, 2, 0);
    chk("post_rst_flush", int'(state_o), 1);

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 19) != 0,
           8'($urandom_range(0, 6)),
           $urandom_range(0, 4) != 0,
           4'($urandom),
           $urandom_range(0, 9) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
